bist_misr: RTL and testbench

Multiple-input signature register (MISR) for the BIST path of the systolic array. The LFSR stimulus generator drives pattern words into the array, and this block sits directly downstream of the array outputs. It compacts a programmed number of valid response words into a DATA_W-bit signature, compares that signature against a golden value, and reports pass/fail to the BIST sequencer. The block is a small FSM with a word counter and a handshake-free valid-qualified data input.

---
 rtl/bist_misr.sv | 98 +++++++++
 tb/tb_bist_misr.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bist_misr.sv
// bist_misr: MISR that compacts a programmed number of BIST response words and checks the result against a golden value.
// Define BIST_MISR_MASK_EN to add the data_mask_i per-bit X-mask input.
module bist_misr #(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] POLY   = 'h1B,
    parameter int                CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic [CNT_W-1:0]  num_words_i,
    input  logic [DATA_W-1:0] golden_i,
    input  logic              data_valid_i,
    input  logic [DATA_W-1:0] data_i,
`ifdef BIST_MISR_MASK_EN
    input  logic [DATA_W-1:0] data_mask_i,
`endif
    output logic [DATA_W-1:0] sig_o,
    output logic [CNT_W-1:0]  word_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o
);
    typedef enum logic [1:0] {IDLE, COMPACT, CHECK, DONE} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sig_q, sig_d, d_word, sig_next;
    logic [CNT_W-1:0]  cnt_q, cnt_d, num_q, num_d, cnt_inc;
    logic              pass_q, pass_d, fail_q, fail_d;

`ifdef BIST_MISR_MASK_EN
    assign d_word = data_i & ~data_mask_i;
`else
    assign d_word = data_i;
`endif

    assign cnt_inc  = cnt_q + 1'b1;
    assign sig_next = {sig_q[DATA_W-2:0], 1'b0} ^ (sig_q[DATA_W-1] ? POLY : '0) ^ d_word;

    // start_i restarts from any state and wins over a same-cycle data word.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        if (start_i) begin
            sig_d   = seed_i;
            cnt_d   = '0;
            num_d   = num_words_i;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            state_d = (num_words_i == '0) ? CHECK : COMPACT;
        end else begin
            case (state_q)
                COMPACT: if (data_valid_i) begin
                    sig_d   = sig_next;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == num_q) ? CHECK : COMPACT;
                end
                CHECK: begin
                    pass_d  = sig_q == golden_i;
                    fail_d  = sig_q != golden_i;
                    state_d = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign sig_o      = sig_q;
    assign word_cnt_o = cnt_q;
    assign busy_o     = (state_q == COMPACT) || (state_q == CHECK);
    assign done_o     = state_q == DONE;
    assign pass_o     = pass_q;
    assign fail_o     = fail_q;
endmodule

// File: tb/tb_bist_misr.sv
// tb_bist_misr: scoreboard bench for bist_misr; a GF(2) polynomial model predicts each run's final result.
module tb_bist_misr;
    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        start_i = 1'b0;
    logic [63:0] seed_i = '0;
    logic [15:0] num_words_i = '0;
    logic [63:0] golden_i = '0;
    logic        data_valid_i = 1'b0;
    logic [63:0] data_i = '0;
    logic [63:0] data_mask_i = '0;
    logic [63:0] sig_o;
    logic [15:0] word_cnt_o;
    logic        busy_o, done_o, pass_o, fail_o;

    typedef struct packed {
        logic [63:0] sig;
        logic [15:0] cnt;
        logic        pass;
        logic        fail;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic done_prev = 1'b0;

    bist_misr dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .seed_i(seed_i),
        .num_words_i(num_words_i), .golden_i(golden_i), .data_valid_i(data_valid_i),
        .data_i(data_i),
`ifdef BIST_MISR_MASK_EN
        .data_mask_i(data_mask_i),
`endif
        .sig_o(sig_o), .word_cnt_o(word_cnt_o), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .fail_o(fail_o)
    );

    always #5 clk_i = ~clk_i;

    // Signature update as multiplication by x modulo x^64+x^4+x^3+x+1, plus the masked word.
    function automatic logic [63:0] model_step(input logic [63:0] s, input logic [63:0] d, input logic [63:0] m);
        logic [64:0] t;
        t = {1'b0, s} * 65'd2;
`ifdef BIST_MISR_MASK_EN
        return t[63:0] ^ (t[64] ? 64'h1B : 64'h0) ^ (d & ~m);
`else
        return t[63:0] ^ (t[64] ? 64'h1B : 64'h0) ^ d;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (done_o && !done_prev) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_done: got done with empty scoreboard expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_sig", sig_o, e.sig);
                check("sb_cnt", 64'(word_cnt_o), 64'(e.cnt));
                check("sb_pass", 64'(pass_o), 64'(e.pass));
                check("sb_fail", 64'(fail_o), 64'(e.fail));
            end
        end
        done_prev <= done_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [63:0] seed, input logic [15:0] n, input logic [63:0] gold);
        start_i = 1'b1;
        seed_i = seed;
        num_words_i = n;
        golden_i = gold;
        tick();
        start_i = 1'b0;
    endtask

    task automatic word(input logic [63:0] d, input logic [63:0] m, input int gap);
        for (int i = 0; i < gap; i++) tick();
        data_valid_i = 1'b1;
        data_i = d;
        data_mask_i = m;
        tick();
        data_valid_i = 1'b0;
    endtask

    task automatic push(input logic [63:0] s, input logic [15:0] n, input logic [63:0] gold);
        exp_t e;
        e.sig = s;
        e.cnt = n;
        e.pass = s == gold;
        e.fail = s != gold;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done_o && k < 20) begin
            tick();
            k++;
        end
        if (!done_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got done_o=0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_sig"}, sig_o, 64'h0);
        check({name, "_cnt"}, 64'(word_cnt_o), 64'h0);
        check({name, "_busy"}, 64'(busy_o), 64'h0);
        check({name, "_done"}, 64'(done_o), 64'h0);
        check({name, "_pass"}, 64'(pass_o), 64'h0);
        check({name, "_fail"}, 64'(fail_o), 64'h0);
    endtask

    initial begin
        logic [63:0] s, g, w[];
        int          n;
        repeat (2) tick();
        check_zero("reset");
        rstn_i = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) word(64'hFFFF, 64'h0, 0);
        check("idle_valid_sig", sig_o, 64'h0);
        check("idle_valid_cnt", 64'(word_cnt_o), 64'h0);

        push(64'h5, 16'd1, 64'h5);
        do_start(64'h0, 16'd1, 64'h5);
        word(64'h5, 64'h0, 0);
        check("w1_sig", sig_o, 64'h5);
        check("w1_check_busy", 64'(busy_o), 64'h1);
        check("w1_check_done", 64'(done_o), 64'h0);
        tick();
        check("w1_done", 64'(done_o), 64'h1);
        check("w1_busy", 64'(busy_o), 64'h0);
        word(64'h1234, 64'h0, 0);
        check("done_ignores_valid", sig_o, 64'h5);

        push(64'h1B, 16'd1, 64'h1A);
        do_start(64'h8000_0000_0000_0000, 16'd1, 64'h1A);
        word(64'h0, 64'h0, 0);
        check("poly_sig", sig_o, 64'h1B);
        wait_done("poly");

        push(64'hABCD, 16'd0, 64'hABCD);
        do_start(64'hABCD, 16'd0, 64'hABCD);
        check("n0_busy", 64'(busy_o), 64'h1);
        check("n0_done", 64'(done_o), 64'h0);
        check("n0_sig", sig_o, 64'hABCD);
        tick();
        check("n0_done2", 64'(done_o), 64'h1);
        check("n0_busy2", 64'(busy_o), 64'h0);

        do_start(64'h1111, 16'd4, 64'h0);
        word(64'hAAAA, 64'h0, 1);
        word(64'hBBBB, 64'h0, 2);
        s = 64'h2222;
        w = new[4];
        for (int i = 0; i < 4; i++) w[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) s = model_step(s, w[i], 64'h0);
        push(s, 16'd4, s);
        data_valid_i = 1'b1;
        data_i = 64'hDEAD;
        do_start(64'h2222, 16'd4, s);
        data_valid_i = 1'b0;
        check("abort_cnt", 64'(word_cnt_o), 64'h0);
        check("abort_sig", sig_o, 64'h2222);
        for (int i = 0; i < 4; i++) word(w[i], 64'h0, i % 2);
        wait_done("abort");

        do_start(64'h3333, 16'd4, 64'h0);
        word(64'h1, 64'h0, 1);
        word(64'h2, 64'h0, 0);
        #2 rstn_i = 1'b0;
        #1 check_zero("midrst");
        tick();
        rstn_i = 1'b1;
        tick();
        check_zero("after_rst");

`ifdef BIST_MISR_MASK_EN
        push(64'h0, 16'd1, 64'h0);
        do_start(64'h0, 16'd1, 64'h0);
        word(64'hFF, 64'hFF, 0);
        check("mask_sig", sig_o, 64'h0);
        wait_done("mask");
`endif

        for (int r = 0; r < 20; r++) begin
            logic [63:0] seed;
            logic [63:0] m[];
            n = $urandom_range(1, 8);
            seed = {$urandom, $urandom};
            w = new[n];
            m = new[n];
            s = seed;
            for (int i = 0; i < n; i++) begin
                w[i] = {$urandom, $urandom};
`ifdef BIST_MISR_MASK_EN
                m[i] = {$urandom, $urandom};
`else
                m[i] = 64'h0;
`endif
                s = model_step(s, w[i], m[i]);
            end
            g = ($urandom_range(0, 1) == 1) ? s : s ^ (64'h1 << $urandom_range(0, 63));
            push(s, 16'(n), g);
            do_start(seed, 16'(n), g);
            for (int i = 0; i < n; i++) word(w[i], m[i], $urandom_range(0, 2));
            tick();
        end
        repeat (3) tick();
        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
